// File: rtl/rgmii_pkg.sv
// Shared constants and types for the RGMII transmit framer.
//   ETH_PREAMBLE / ETH_SFD : framing bytes
//   CRC32_POLY / CRC32_INIT: reflected Ethernet CRC-32 constants
//   tx_state_e             : framer state encoding
//   tx_byte_t              : one byte-time on the wire (data + TX_EN + TX_ER)
package rgmii_pkg;
  localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
  localparam logic [7:0]  ETH_SFD      = 8'hD5;
  localparam logic [31:0] CRC32_POLY   = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;

  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, DRAIN, IFG} tx_state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       en;
    logic       er;
  } tx_byte_t;
endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 step over one byte, reflected polynomial, LSB first.
//   crc_in  : running CRC register
//   data    : byte to absorb
//   crc_out : CRC register after absorbing data
module crc32_d8
  import rgmii_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);
  logic [31:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC32_POLY;
      else                c = c >> 1;
    end
    crc_out = c;
  end
endmodule

// File: rtl/rgmii_tx_framer.sv
// RGMII transmit framer: turns a valid/ready/last byte stream into a full
// Ethernet frame (preamble, SFD, payload, pad, FCS, inter-frame gap) and
// presents each byte as registered rising/falling-edge nibbles for the oddr lanes.
//   i_clk, i_rstn            : 125 MHz byte clock, async active-low reset
//   s_tdata/tvalid/tready/tlast : payload stream in
//   o_txd_d0/d1              : byte[3:0] / byte[7:4]
//   o_txctl_d0/d1            : TX_EN / TX_EN^TX_ER
//   o_busy                   : not IDLE
//   o_frame_done             : pulse with last byte of a good frame
//   o_frame_cnt / o_err_cnt  : good / aborted frame counters (wrapping)
module rgmii_tx_framer
  import rgmii_pkg::*;
#(
  parameter int PREAMBLE_BYTES  = 7,
  parameter int MIN_FRAME_BYTES = 60,
  parameter int IFG_BYTES       = 12,   // must be >= 2
  parameter bit ENABLE_PAD      = 1'b1,
  parameter bit ENABLE_FCS      = 1'b1,
  parameter int CNT_W           = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [7:0]       s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic             s_tlast,
  output logic [3:0]       o_txd_d0,
  output logic [3:0]       o_txd_d1,
  output logic             o_txctl_d0,
  output logic             o_txctl_d1,
  output logic             o_busy,
  output logic             o_frame_done,
  output logic [CNT_W-1:0] o_frame_cnt,
  output logic [CNT_W-1:0] o_err_cnt
);
  localparam int LW = $clog2(MIN_FRAME_BYTES + 1);
  localparam int BW = $clog2(PREAMBLE_BYTES + IFG_BYTES + 4) + 1;
  localparam tx_state_e TAIL = ENABLE_FCS ? FCS : IFG;

  tx_state_e   state, state_nx;
  logic [BW-1:0] cnt;
  logic [LW-1:0] len, len_inc;
  logic [31:0] crc, crc_nx, fcs;
  tx_byte_t    nxt;
  logic        crc_en, done_c, abort_c, pad_needed;

  // Length after the byte going out this cycle; saturates at the minimum.
  assign len_inc    = (len == LW'(MIN_FRAME_BYTES)) ? len : len + 1'b1;
  assign pad_needed = ENABLE_PAD && (len_inc < LW'(MIN_FRAME_BYTES));
  assign fcs        = ~crc;
  assign o_busy     = (state != IDLE);

  crc32_d8 u_crc (.crc_in(crc), .data(nxt.data), .crc_out(crc_nx));

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= IDLE;
    else         state <= state_nx;
  end

  // IFG holds IFG_BYTES-1 cycles; the mandatory IDLE cycle that follows
  // supplies the last idle byte-time, so back-to-back frames see exactly IFG_BYTES.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (s_tvalid) state_nx = PRE;
      PRE:   if (cnt == BW'(PREAMBLE_BYTES - 1)) state_nx = SFD;
      SFD:   state_nx = DATA;
      DATA:  if (!s_tvalid)    state_nx = DRAIN;
             else if (s_tlast) state_nx = pad_needed ? PAD : TAIL;
      PAD:   if (len_inc == LW'(MIN_FRAME_BYTES)) state_nx = TAIL;
      FCS:   if (cnt == BW'(3)) state_nx = IFG;
      DRAIN: if (s_tvalid && s_tlast) state_nx = IFG;
      IFG:   if (cnt == BW'(IFG_BYTES - 2)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    nxt      = '0;
    s_tready = 1'b0;
    crc_en   = 1'b0;
    done_c   = 1'b0;
    abort_c  = 1'b0;
    case (state)
      PRE: begin nxt.data = ETH_PREAMBLE; nxt.en = 1'b1; end
      SFD: begin nxt.data = ETH_SFD;      nxt.en = 1'b1; end
      DATA: begin
        s_tready = 1'b1;
        nxt.en   = 1'b1;
        if (s_tvalid) begin
          nxt.data = s_tdata;
          crc_en   = 1'b1;
          done_c   = s_tlast && !pad_needed && !ENABLE_FCS;
        end else begin
          // Underflow: TX_ER with zero data marks the frame as corrupt.
          nxt.er  = 1'b1;
          abort_c = 1'b1;
        end
      end
      PAD: begin
        nxt.en = 1'b1;
        crc_en = 1'b1;
        done_c = !ENABLE_FCS && (len_inc == LW'(MIN_FRAME_BYTES));
      end
      FCS: begin
        nxt.en   = 1'b1;
        nxt.data = fcs[{cnt[1:0], 3'b000} +: 8];
        done_c   = (cnt == BW'(3));
      end
      DRAIN: s_tready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt          <= '0;
      len          <= '0;
      crc          <= CRC32_INIT;
      o_txd_d0     <= '0;
      o_txd_d1     <= '0;
      o_txctl_d0   <= 1'b0;
      o_txctl_d1   <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_cnt  <= '0;
      o_err_cnt    <= '0;
    end else begin
      cnt <= (state_nx != state) ? '0 : cnt + 1'b1;
      if (state == SFD)  len <= '0;
      else if (crc_en)   len <= len_inc;
      if (state == SFD)  crc <= CRC32_INIT;
      else if (crc_en)   crc <= crc_nx;
      o_txd_d0     <= nxt.data[3:0];
      o_txd_d1     <= nxt.data[7:4];
      o_txctl_d0   <= nxt.en;
      o_txctl_d1   <= nxt.en ^ nxt.er;
      o_frame_done <= done_c;
      if (done_c)  o_frame_cnt <= o_frame_cnt + 1'b1;
      if (abort_c) o_err_cnt   <= o_err_cnt + 1'b1;
    end
  end
endmodule

// File: doc/rgmii_tx_framer.md
Name: rgmii_tx_framer

Overview:
- Parametrised successor to the fixed-ROM RGMII transmit path.
- Accepts a byte stream over a valid/ready/last handshake and builds a full Ethernet frame: preamble, SFD, payload, pad to minimum length, CRC-32 FCS, inter-frame gap.
- Drives one byte per 125 MHz clock as low/high nibble pairs plus a ctrl pair. These feed the existing oddr/DELAYG lanes (D0 = rising edge, D1 = falling edge).
- Adds behaviour the fixed-ROM transmitter lacks: TX_ER signalling on mid-frame underflow, and frame statistics.

Parameters:
PREAMBLE_BYTES, 7, count of 0x55 bytes sent before the SFD.
MIN_FRAME_BYTES, 60, minimum payload+pad length, excluding FCS. Pad bytes are 0x00.
IFG_BYTES, 12, idle byte-times forced after each frame's last FCS byte (or after an aborted frame).
ENABLE_PAD, 1, 1 = pad short frames to MIN_FRAME_BYTES; 0 = no padding.
ENABLE_FCS, 1, 1 = append 4-byte CRC-32; 0 = frame ends at the last payload/pad byte.
CNT_W, 16, width of the frame and error counters.

Ports:
i_clk  in  1  125 MHz TX byte clock; one clock, all logic on its rising edge.
i_rstn  in  1  Reset: asynchronous assert, active-low.
s_tdata  in  8  Payload byte.
s_tvalid  in  1  Payload byte valid.
s_tready  out  1  Byte accepted when s_tvalid & s_tready.
s_tlast  in  1  Marks the last payload byte of a frame.
o_txd_d0  out  4  Nibble for rising edge = byte[3:0].
o_txd_d1  out  4  Nibble for falling edge = byte[7:4].
o_txctl_d0  out  1  TX_EN.
o_txctl_d1  out  1  TX_EN xor TX_ER.
o_busy  out  1  High in any state other than IDLE.
o_frame_done  out  1  One-cycle pulse with the last transmitted byte of a good frame.
o_frame_cnt  out  CNT_W  Good frames sent; wraps at the counter width.
o_err_cnt  out  CNT_W  Aborted frames; wraps at the counter width.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0, CRC = 0xFFFFFFFF.
- Output register: all o_txd*/o_txctl* outputs are registered. A byte chosen in cycle k appears at k+1.
- s_tready is combinational and high only in DATA and DRAIN.

State machine:
- IDLE: when s_tvalid=1, go to PRE and clear the byte counter. s_tvalid is sampled, not consumed.
- PRE: emit 0x55 for PREAMBLE_BYTES cycles, then go to SFD.
- SFD: emit 0xD5 for one cycle. Reset CRC to 0xFFFFFFFF. Go to DATA.
- DATA, handshake (s_tvalid=1):
  - Emit s_tdata and update the CRC.
  - Increment the length counter, which saturates at MIN_FRAME_BYTES.
  - On s_tlast: if ENABLE_PAD and the length is below MIN_FRAME_BYTES, go to PAD. Otherwise go to FCS if ENABLE_FCS, else to IFG.
- DATA, underflow (s_tvalid=0):
  - Emit the error byte 0x00 with ctl d0=1, d1=0.
  - Increment o_err_cnt.
  - Go to DRAIN.
- PAD: emit 0x00 and update the CRC until the length reaches MIN_FRAME_BYTES. Then go to FCS, or to IFG if ENABLE_FCS=0.
- FCS: emit ~CRC as 4 bytes, least significant byte first, then go to IFG.
- DRAIN: TX_EN=0. Accept and discard bytes until the s_tlast beat, then go to IFG.
- IFG: TX_EN=0 and txd=0 for IFG_BYTES cycles, then go to IDLE. s_tvalid is ignored during IFG.

Control and CRC rules:
- TX_EN (d0=d1=1) is asserted in PRE, SFD, DATA, PAD and FCS; it is 0 elsewhere.
- o_frame_done pulses with the last FCS byte (or last data/pad byte when ENABLE_FCS=0), and o_frame_cnt increments in the same cycle.
- CRC-32 is the reflected polynomial 0xEDB88320, processed LSB first, with init all-ones and final invert.
- s_tlast together with s_tvalid in the same beat in which padding completes: the pad decision is based on the length after that byte.
- Reset during a frame: outputs drop to 0 immediately and the frame is truncated; no error is counted.

Decomposition:
- Package rgmii_pkg holds: ETH_PREAMBLE 8'h55, ETH_SFD 8'hD5, CRC32_POLY 32'hEDB88320, CRC32_INIT 32'hFFFFFFFF, and the state enum (IDLE, PRE, SFD, DATA, PAD, FCS, DRAIN, IFG).
- Sub-module crc32_d8: purely combinational next-CRC function from (crc_in[31:0], byte[7:0]).
- oddr/DELAYG instances stay outside this block.

Test Plan:
1. Defaults with ENABLE_PAD=0 and payload "123456789" (0x31..0x39) with s_tvalid held high:
   - Required: 7×0x55, then 0xD5, then the 9 bytes, then FCS 26 39 F4 CB.
   - TX_EN high for exactly 21 cycles; 12 idle cycles follow.
   - o_frame_done pulses once and o_frame_cnt reads 1.
2. Defaults with a 14-byte payload:
   - Required: 46 bytes of 0x00 pad, then FCS.
   - Frame of 8+60+4 = 72 TX_EN cycles; FCS checked against a reference CRC model.
3. s_tvalid dropped after payload byte 5, tlast arriving 3 beats later:
   - Required: one cycle with ctl d0=1/d1=0 and txd 0x00, then TX_EN=0.
   - The 3 remaining beats are accepted and discarded; o_err_cnt=1 and o_frame_cnt unchanged.
4. Two back-to-back frames with s_tvalid held high:
   - Required: exactly IFG_BYTES=12 cycles with TX_EN=0 between the last FCS byte and the next preamble byte.
   - s_tready stays low throughout PRE, SFD and IFG.
5. i_rstn asserted during the DATA state:
   - Required: all outputs 0 asynchronously, and the state returns to IDLE.
   - After release, a new frame transmits correctly and both counters read 0.
6. Run with ENABLE_FCS=0 and PREAMBLE_BYTES=3:
   - Required: 3×0x55, then 0xD5, then the payload.
   - TX_EN drops right after the last payload byte, and o_frame_done pulses with that byte.
